// File: rtl/sa_fifo_ctrl_64x129_pkg.sv
// Shared constants and types for the 64x129 RAM-backed valid/ready FIFO controller.
package sa_fifo_ctrl_64x129_pkg;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 129;
  localparam int SKID  = 3;
  localparam int SPW   = $clog2(SKID);
  localparam int SCW   = $clog2(SKID + 1);

  typedef logic [AW-1:0]  ptr_t;
  typedef logic [AW:0]    cnt_t;
  typedef logic [DW-1:0]  data_t;
  typedef logic [SPW-1:0] sptr_t;
  typedef logic [SCW-1:0] scnt_t;

  // Skid pointer increment, wrapping at SKID (not necessarily a power of 2).
  function automatic sptr_t sptr_inc(input sptr_t p);
    return (p == sptr_t'(SKID - 1)) ? '0 : p + sptr_t'(1);
  endfunction

endpackage

// File: rtl/sa_fifo_ctrl_64x129_if.sv
// Valid/ready word stream; master drives valid/data, slave drives ready.
interface sa_fifo_ctrl_64x129_if;
  import sa_fifo_ctrl_64x129_pkg::*;

  logic  pvld;
  logic  prdy;
  data_t pd;

  modport master (output pvld, output pd, input prdy);
  modport slave  (input pvld, input pd, output prdy);

endinterface

// File: rtl/sa_fifo_ctrl_64x129_skid.sv
// SKID-entry registered FIFO that re-times RAM read data toward the consumer.
module sa_fifo_skid_buf
  import sa_fifo_ctrl_64x129_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  data_t din,
  input  logic  out_prdy,
  output logic  out_pvld,
  output data_t out_pd,
  output logic  pop,
  output scnt_t cnt
);

  data_t mem_q [SKID];
  data_t mem_d [SKID];
  sptr_t wr_q, wr_d;
  sptr_t rd_q, rd_d;
  scnt_t cnt_q, cnt_d;

  assign out_pvld = (cnt_q != '0);
  assign pop      = out_pvld & out_prdy;
  // Head is a register read; masking keeps out_pd at zero while empty.
  assign out_pd   = out_pvld ? mem_q[rd_q] : '0;
  assign cnt      = cnt_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = sptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = sptr_inc(rd_q);
    end
    cnt_d = cnt_q + scnt_t'(push) - scnt_t'(pop);
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Data storage, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == scnt_t'(SKID))));

endmodule

// File: rtl/sa_fifo_ctrl_64x129.sv
// Valid/ready FIFO controller sequencing an external 64x129 two-port RAM
// (registered read address, output register enabled by ram_ore).
module sa_fifo_ctrl_64x129
  import sa_fifo_ctrl_64x129_pkg::*;
(
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  sa_fifo_ctrl_64x129_if.slave         in_if,
  sa_fifo_ctrl_64x129_if.master        out_if,
  output ptr_t                         ram_wa,
  output logic                         ram_we,
  output data_t                        ram_di,
  output ptr_t                         ram_ra,
  output logic                         ram_re,
  output logic                         ram_ore,
  input  data_t                        ram_dout,
  output logic                         idle
);

  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  avail_q, avail_d;
  cnt_t  ram_cnt_q, ram_cnt_d;
  logic  ore_q, ore_d;
  logic  dout_vld_q, dout_vld_d;

  logic       wr_en;
  logic       rd_en;
  logic [1:0] inflight;
  logic [SCW:0] occ;
  logic       skid_pop;
  scnt_t      skid_cnt;

  // A slot is released only when ore captures it, so an in-flight read
  // address can never be overwritten.
  assign in_if.prdy = (ram_cnt_q != cnt_t'(DEPTH));
  assign wr_en      = in_if.pvld & in_if.prdy;

  // Reads issued but not yet pushed: one in the ore stage, one on ram_dout.
  assign inflight = {1'b0, ore_q} + {1'b0, dout_vld_q};
  // Occupancy seen by the issue logic credits this cycle's pop, which is what
  // lets three skid entries sustain one word per cycle over a 2-cycle read.
  assign occ   = (SCW+1)'(inflight) + (SCW+1)'(skid_cnt) - (SCW+1)'(skid_pop);
  assign rd_en = (avail_q != '0) && (occ < (SCW+1)'(SKID));

  assign ram_wa  = wr_ptr_q;
  assign ram_we  = wr_en;
  assign ram_di  = in_if.pd;
  assign ram_ra  = rd_ptr_q;
  assign ram_re  = rd_en;
  assign ram_ore = ore_q;
  assign idle    = (ram_cnt_q == '0) && !dout_vld_q && (skid_cnt == '0);

  // Next-state for pointers, counters and the re->ore->push pipe.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ptr_t'(wr_en);
    rd_ptr_d   = rd_ptr_q + ptr_t'(rd_en);
    avail_d    = avail_q + cnt_t'(wr_en) - cnt_t'(rd_en);
    ram_cnt_d  = ram_cnt_q + cnt_t'(wr_en) - cnt_t'(ore_q);
    ore_d      = rd_en;
    dout_vld_d = ore_q;
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      avail_q    <= '0;
      ram_cnt_q  <= '0;
      ore_q      <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      avail_q    <= avail_d;
      ram_cnt_q  <= ram_cnt_d;
      ore_q      <= ore_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  sa_fifo_skid_buf u_skid (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .push     (dout_vld_q),
    .din      (ram_dout),
    .out_prdy (out_if.prdy),
    .out_pvld (out_if.pvld),
    .out_pd   (out_if.pd),
    .pop      (skid_pop),
    .cnt      (skid_cnt)
  );

endmodule

// File: tb/tb_sa_fifo_ctrl_64x129.sv
// Bench for sa_fifo_ctrl_64x129 with a behavioural 64x129 RAM alongside.
module tb_sa_fifo_ctrl_64x129;
  import sa_fifo_ctrl_64x129_pkg::*;

  logic  clk;
  logic  rst_n;
  ptr_t  ram_wa, ram_ra;
  logic  ram_we, ram_re, ram_ore, idle;
  data_t ram_di, ram_dout;

  sa_fifo_ctrl_64x129_if in_if ();
  sa_fifo_ctrl_64x129_if out_if ();

  sa_fifo_ctrl_64x129 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .in_if           (in_if),
    .out_if          (out_if),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_dout        (ram_dout),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read address, output register loaded on ore.
  data_t mem [DEPTH];
  ptr_t  ra_q;
  data_t dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end
  assign ram_dout = dout_q;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input data_t got, input data_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and address model, sampled on the falling edge.
  data_t q[$];
  ptr_t  exp_wa, exp_ra;
  logic  prev_re;
  int    n_re  = 0;
  int    n_pop = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_wa  = '0;
      exp_ra  = '0;
      prev_re = 1'b0;
    end else begin
      chk("ore_after_re", DW'(ram_ore), DW'(prev_re));
      chk("ram_wa", DW'(ram_wa), DW'(exp_wa));
      chk("ram_ra", DW'(ram_ra), DW'(exp_ra));
      prev_re = ram_re;
      if (in_if.pvld && in_if.prdy) begin
        q.push_back(in_if.pd);
        exp_wa = exp_wa + ptr_t'(1);
      end
      if (ram_re) begin
        exp_ra = exp_ra + ptr_t'(1);
        n_re++;
      end
      if (out_if.pvld && out_if.prdy) begin
        n_pop++;
        if (q.size() == 0) chk("pop_empty", DW'(1), DW'(0));
        else chk("data", out_if.pd, q.pop_front());
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_prdy"},  DW'(in_if.prdy),  DW'(1));
    chk({tag, "_out_pvld"}, DW'(out_if.pvld), DW'(0));
    chk({tag, "_out_pd"},   out_if.pd,        DW'(0));
    chk({tag, "_ram_we"},   DW'(ram_we),      DW'(0));
    chk({tag, "_ram_re"},   DW'(ram_re),      DW'(0));
    chk({tag, "_ram_ore"},  DW'(ram_ore),     DW'(0));
    chk({tag, "_ram_wa"},   DW'(ram_wa),      DW'(0));
    chk({tag, "_ram_ra"},   DW'(ram_ra),      DW'(0));
    chk({tag, "_idle"},     DW'(idle),        DW'(1));
  endtask

  // Present one word and hold it until accepted; returns at posedge+1.
  task automatic send(input data_t w);
    logic acc;
    acc = 1'b0;
    in_if.pvld = 1'b1;
    in_if.pd   = w;
    for (int k = 0; k < 1000 && !acc; k++) begin
      @(negedge clk);
      acc = in_if.prdy;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", DW'(0), DW'(1));
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      @(negedge clk);
      done = idle && !out_if.pvld;
    end
    chk({tag, "_idle"}, DW'(done), DW'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n_acc, re0, pop0, sent, run;
    logic  seen;
    data_t w;

    rst_n       = 1'b0;
    in_if.pvld  = 1'b0;
    in_if.pd    = '0;
    out_if.prdy = 1'b0;
    #3;
    chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release.
    repeat (8) begin
      @(negedge clk);
      chk("t1_re",   DW'(ram_re),      DW'(0));
      chk("t1_pvld", DW'(out_if.pvld), DW'(0));
      chk("t1_idle", DW'(idle),        DW'(1));
      chk("t1_prdy", DW'(in_if.prdy),  DW'(1));
    end
    @(posedge clk); #1;

    // Single word latency: re c1, ore c2, out_pvld c4 only.
    in_if.pvld  = 1'b1;
    in_if.pd    = 129'h1_DEAD_BEEF;
    out_if.prdy = 1'b1;
    @(negedge clk);
    chk("t2_acc", DW'(in_if.prdy), DW'(1));
    @(posedge clk); #1;
    in_if.pvld = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t2_re",   DW'(ram_re),      DW'(c == 1));
      chk("t2_ore",  DW'(ram_ore),     DW'(c == 2));
      chk("t2_pvld", DW'(out_if.pvld), DW'(c == 4));
      chk("t2_idle", DW'(idle),        DW'(c == 5));
      if (c == 4) chk("t2_pd", out_if.pd, 129'h1_DEAD_BEEF);
      @(posedge clk); #1;
    end

    // 200-word stream: unbroken output run, pointers wrap through the monitor.
    re0 = n_re;
    fork
      begin
        for (int i = 0; i < 200; i++) send(DW'(32'h100 + i));
        in_if.pvld = 1'b0;
      end
      begin
        seen = 1'b0;
        run  = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(negedge clk);
          seen = out_if.pvld;
        end
        while (out_if.pvld && run < 1000) begin
          run++;
          @(negedge clk);
        end
        chk("t3_run", DW'(run), DW'(200));
      end
    join
    wait_idle("t3");
    chk("t3_issues", DW'(n_re - re0), DW'(200));

    // Fill with consumer stalled: 64 in RAM + 3 read out.
    out_if.prdy = 1'b0;
    re0   = n_re;
    pop0  = n_pop;
    n_acc = 0;
    in_if.pvld = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_if.pd = DW'(32'h4000 + n_acc);
      @(negedge clk);
      if (!in_if.prdy) break;
      n_acc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_if.pvld = 1'b0;
    chk("t4_accepted", DW'(n_acc), DW'(67));
    repeat (5) begin
      @(negedge clk);
      chk("t4_full_prdy", DW'(in_if.prdy), DW'(0));
      chk("t4_full_re",   DW'(ram_re),     DW'(0));
    end
    chk("t4_issues", DW'(n_re - re0), DW'(3));
    @(posedge clk); #1;
    out_if.prdy = 1'b1;
    wait_idle("t4");
    chk("t4_drained", DW'(n_pop - pop0), DW'(67));

    // Random valid (70%) and ready (50%), 5000 words.
    pop0 = n_pop;
    sent = 0;
    for (int k = 0; k < 60000 && sent < 5000; k++) begin
      w = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      in_if.pvld  = ($urandom_range(0, 99) < 70);
      in_if.pd    = w;
      out_if.prdy = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (in_if.pvld && in_if.prdy) sent++;
      @(posedge clk); #1;
    end
    in_if.pvld  = 1'b0;
    out_if.prdy = 1'b1;
    chk("t5_sent", DW'(sent), DW'(5000));
    wait_idle("t5");
    chk("t5_popped", DW'(n_pop - pop0), DW'(5000));
    chk("t5_sb_empty", DW'(q.size()), DW'(0));

    // Reset mid-operation with data queued and reads in flight.
    out_if.prdy = 1'b0;
    for (int i = 0; i < 12; i++) send(DW'(32'h6000 + i));
    in_if.pvld  = 1'b0;
    out_if.prdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_pvld", DW'(out_if.pvld), DW'(1));
    chk("t6_pre_busy", DW'(idle),        DW'(0));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(DW'(5));
    in_if.pvld = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = out_if.pvld;
    end
    chk("t6_seen", DW'(seen), DW'(1));
    chk("t6_first", out_if.pd, DW'(5));
    @(posedge clk); #1;
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
